// File: rtl/axi4_pkg.sv
// Shared AXI4 read-side types, constants and the burst length helper.
package axi4_pkg;

  localparam int unsigned BLEN_W = 9;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_FIN  = 2'b11
  } rd_state_t;

  // Beats in the next burst: min(remaining, max_burst, beats left before the next 4 KB page).
  function automatic logic [BLEN_W-1:0] calc_burst_len(
    input logic [11:0] addr,
    input logic [15:0] remaining,
    input int unsigned max_burst,
    input int unsigned bytes_per_beat
  );
    logic [16:0] to_4k;
    logic [16:0] lim;
    to_4k = (17'd4096 - 17'(addr)) / 17'(bytes_per_beat);
    lim   = 17'(max_burst);
    if (17'(remaining) < lim) lim = 17'(remaining);
    if (to_4k < lim) lim = to_4k;
    return BLEN_W'(lim);
  endfunction

endpackage

// File: rtl/axi4_rd_intf.sv
// AXI4 read address + read data channels; AR fields carry no "ar" prefix.
interface axi4_rd_intf #(
  parameter int unsigned DWIDTH  = 64,
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned IDWIDTH = 1
);
  logic [IDWIDTH-1:0] id;
  logic [AWIDTH-1:0]  addr;
  logic [7:0]         len;
  logic [2:0]         size;
  logic [1:0]         burst;
  logic               lock;
  logic [3:0]         cache;
  logic [2:0]         prot;
  logic [3:0]         region;
  logic [3:0]         qos;
  logic               valid;
  logic               ready;
  logic [IDWIDTH-1:0] rid;
  logic [DWIDTH-1:0]  rdata;
  logic [1:0]         rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  modport host (
    output id, addr, len, size, burst, lock, cache, prot, region, qos, valid, rready,
    input  ready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  id, addr, len, size, burst, lock, cache, prot, region, qos, valid, rready,
    output ready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_burst_calc.sv
// Combinational burst length: bounded by remaining beats, MAX_BURST and the 4 KB page.
module axi4_burst_calc
  import axi4_pkg::*;
#(
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned BYTES_PER_BEAT = 8
) (
  input  logic [11:0]       addr_lo,
  input  logic [15:0]       remaining,
  output logic [BLEN_W-1:0] blen_c
);

  always_comb begin
    blen_c = calc_burst_len(addr_lo, remaining, MAX_BURST, BYTES_PER_BEAT);
  end

endmodule

// File: rtl/axi4_rd_dma_engine.sv
// Host-side AXI4 read engine: splits a (addr, beats) command into INCR bursts
// and streams the returned data out with last/done/err status.
module axi4_rd_dma_engine
  import axi4_pkg::*;
#(
  parameter int unsigned DWIDTH    = 64,
  parameter int unsigned AWIDTH    = 32,
  parameter int unsigned IDWIDTH   = 1,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned RD_ID     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [15:0]       cmd_beats,
  axi4_rd_intf.host         m_axi,
  output logic [DWIDTH-1:0] dout_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned BPB    = DWIDTH / 8;
  localparam int unsigned SIZE_W = $clog2(BPB);

  rd_state_t          state_q, state_d;
  logic [AWIDTH-1:0]  cur_addr_q, cur_addr_d;
  logic [15:0]        remaining_q, remaining_d;
  logic [BLEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic               err_q, err_d;
  logic [BLEN_W-1:0]  blen_c;
  logic               beat_fire_c;
  logic               in_data_c;
  logic               beat_bad_c;

  axi4_burst_calc #(
    .MAX_BURST      (MAX_BURST),
    .BYTES_PER_BEAT (BPB)
  ) u_burst_calc (
    .addr_lo   (cur_addr_q[11:0]),
    .remaining (remaining_q),
    .blen_c    (blen_c)
  );

  assign in_data_c   = (state_q == ST_DATA);
  assign beat_fire_c = in_data_c & m_axi.rvalid & dout_ready;
  // Protocol checks on a delivered beat: bad response, foreign ID, or rlast out of place.
  assign beat_bad_c  = (m_axi.rresp != 2'(RESP_OKAY))
                     | (m_axi.rid != IDWIDTH'(RD_ID))
                     | (m_axi.rlast != (beat_cnt_q == BLEN_W'(1)));

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cur_addr_d  = cmd_addr & ~AWIDTH'(BPB - 1);
          remaining_d = cmd_beats;
          err_d       = 1'b0;
          state_d     = (cmd_beats == 16'd0) ? ST_FIN : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axi.ready) begin
          beat_cnt_d  = blen_c;
          cur_addr_d  = cur_addr_q + (AWIDTH'(blen_c) << SIZE_W);
          remaining_d = remaining_q - 16'(blen_c);
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_fire_c) begin
          beat_cnt_d = beat_cnt_q - BLEN_W'(1);
          if (beat_bad_c) err_d = 1'b1;
          if (beat_cnt_q == BLEN_W'(1)) begin
            state_d = (remaining_q != 16'd0) ? ST_ADDR : ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

  // AR fields depend only on flops that hold still while ADDR waits for ready.
  assign m_axi.id     = IDWIDTH'(RD_ID);
  assign m_axi.addr   = cur_addr_q;
  assign m_axi.len    = 8'(blen_c - BLEN_W'(1));
  assign m_axi.size   = 3'(SIZE_W);
  assign m_axi.burst  = 2'(BURST_INCR);
  assign m_axi.lock   = 1'b0;
  assign m_axi.cache  = AXI_CACHE_DEFAULT;
  assign m_axi.prot   = 3'b000;
  assign m_axi.region = 4'h0;
  assign m_axi.qos    = 4'h0;
  assign m_axi.valid  = (state_q == ST_ADDR);

  assign m_axi.rready = in_data_c & dout_ready;
  assign dout_data    = m_axi.rdata;
  assign dout_valid   = in_data_c & m_axi.rvalid;
  assign dout_last    = in_data_c & (beat_cnt_q == BLEN_W'(1)) & (remaining_q == 16'd0);

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign err       = err_q;

endmodule

// File: tb/tb_axi4_rd_dma_engine.sv
// Self-checking bench: reactive AXI read slave, scoreboard queues for AR and data beats.
module tb_axi4_rd_dma_engine;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 1;
  localparam int          MB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [15:0]   cmd_beats = '0;
  logic [DW-1:0] dout_data;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          dout_last;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  axi4_rd_intf #(.DWIDTH(DW), .AWIDTH(AW), .IDWIDTH(IW)) axi ();

  axi4_rd_dma_engine #(
    .DWIDTH(DW), .AWIDTH(AW), .IDWIDTH(IW), .MAX_BURST(MB), .RD_ID(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .m_axi(axi),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [15:0] beats;
    int          err_at;
    int          exp_nar;
    logic        exp_err;
  } vec_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [63:0] data; logic last; } beat_t;

  ar_t   exp_ar[$];
  beat_t exp_dout[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    gbeat_total = 0;
  int    err_target = -1;
  int    beats_seen = 0;
  int    ar_count = 0;
  int    last_cyc = -10;
  int    rv_pct = 70;
  int    ar_pct = 60;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {~a, a ^ 32'h5A5A_0000};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave + monitor: drive at negedge, sample handshakes 1 unit later.
  initial begin : slave
    logic        have, ar_fire, r_fire;
    logic [31:0] s_addr, ar_addr_s;
    logic [7:0]  ar_len_s;
    int          s_len, s_idx;
    have = 1'b0; ar_fire = 1'b0; r_fire = 1'b0;
    s_addr = '0; ar_addr_s = '0; ar_len_s = '0; s_len = 0; s_idx = 0;
    axi.ready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
    axi.rresp = 2'b00; axi.rdata = '0; axi.rid = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = 1'b0; ar_fire = 1'b0; r_fire = 1'b0;
        axi.ready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
      end else begin
        if (ar_fire) begin
          have = 1'b1; s_addr = ar_addr_s; s_len = int'(ar_len_s); s_idx = 0;
        end
        if (r_fire) begin
          s_idx++; gbeat_total++;
          if (s_idx > s_len) have = 1'b0;
        end
        axi.ready = !have && ($urandom_range(99) < 32'(ar_pct));
        if (!axi.rvalid || r_fire) axi.rvalid = have && ($urandom_range(99) < 32'(rv_pct));
        axi.rdata = pat(s_addr + 32'(s_idx * 8));
        axi.rlast = (s_idx == s_len);
        axi.rresp = (gbeat_total == err_target) ? 2'b10 : 2'b00;
        axi.rid   = '0;
        #1;
        ar_fire = axi.valid && axi.ready;
        ar_addr_s = axi.addr;
        ar_len_s  = axi.len;
        r_fire = axi.rvalid && axi.rready;
        if (ar_fire) begin
          ar_count++;
          if (exp_ar.size() == 0) begin
            chk("unexpected_ar", 64'(axi.addr), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            ar_t e;
            e = exp_ar.pop_front();
            chk("ar_addr", 64'(axi.addr), 64'(e.addr));
            chk("ar_len", 64'(axi.len), 64'(e.len));
          end
        end
        if (dout_valid && dout_ready) begin
          beats_seen++;
          if (exp_dout.size() == 0) begin
            chk("unexpected_beat", dout_data, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            beat_t b;
            b = exp_dout.pop_front();
            chk("dout_data", dout_data, b.data);
            chk("dout_last", 64'(dout_last), 64'(b.last));
          end
          if (dout_last) last_cyc = cyc;
        end
      end
    end
  end

  // Reference split: min(remaining, MAX_BURST, beats to the next 4 KB page).
  task automatic model_push(input logic [31:0] addr, input logic [15:0] beats);
    logic [31:0] a;
    int r, n, room;
    a = addr & ~32'h7;
    for (int i = 0; i < int'(beats); i++) begin
      beat_t b;
      b.data = pat(a + 32'(i * 8));
      b.last = (i == int'(beats) - 1);
      exp_dout.push_back(b);
    end
    r = int'(beats);
    while (r > 0) begin
      ar_t t;
      room = (4096 - int'(a[11:0])) / 8;
      n = r;
      if (n > MB) n = MB;
      if (n > room) n = room;
      t.addr = a;
      t.len  = 8'(n - 1);
      exp_ar.push_back(t);
      a = a + 32'(n * 8);
      r = r - n;
    end
  endtask

  task automatic run_cmd(input vec_t v, input int mode);
    int b0, a0, n, pi, done_cyc, fire_now;
    logic got, err_seen;
    logic [3:0] rpat;
    rpat = 4'b1001;
    @(negedge clk); #2;
    err_target = (v.err_at < 0) ? -1 : gbeat_total + v.err_at;
    model_push(v.addr, v.beats);
    b0 = beats_seen; a0 = ar_count;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_beats = v.beats; dout_ready = 1'b1;
    #2;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #2;
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    chk("err_clear_on_accept", 64'(err), 64'd0);
    got = 1'b0; err_seen = 1'b0; n = 0; pi = 0; done_cyc = 0;
    while (!got && n < 3000) begin
      if (dout_valid) chk("rready_mirror", 64'(axi.rready), 64'(dout_ready));
      if (!err_seen && err) begin
        err_seen = 1'b1;
        fire_now = (dout_valid && dout_ready) ? 1 : 0;
        if (v.err_at >= 0) chk("err_timing_beats", 64'(beats_seen - b0 - fire_now), 64'(v.err_at + 1));
      end
      if (done) begin
        got = 1'b1; done_cyc = cyc;
      end else begin
        @(negedge clk);
        if (mode == 1) begin
          dout_ready = rpat[pi % 4]; pi++;
        end else begin
          dout_ready = ($urandom_range(3) != 0);
        end
        #2;
        n++;
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    if (v.beats == 16'd0) chk("zero_done_latency_ok", 64'(n <= 1), 64'd1);
    else chk("done_after_last", 64'(done_cyc), 64'(last_cyc + 1));
    dout_ready = 1'b1;
    @(negedge clk); #2;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("cmd_ready_back", 64'(cmd_ready), 64'd1);
    chk("err_final", 64'(err), 64'(v.exp_err));
    chk("beat_count", 64'(beats_seen - b0), 64'(v.beats));
    chk("ar_count", 64'(ar_count - a0), 64'(v.exp_nar));
    chk("dout_queue_empty", 64'(exp_dout.size()), 64'd0);
    chk("ar_queue_empty", 64'(exp_ar.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, 64'(axi.valid), 64'd0);
    chk({tag, "_rready"}, 64'(axi.rready), 64'd0);
    chk({tag, "_dout_valid"}, 64'(dout_valid), 64'd0);
    chk({tag, "_dout_last"}, 64'(dout_last), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin : main
    vec_t vecs[8];
    vec_t v;
    int b0, n;
    vecs[0] = '{32'h0000_1000, 16'd1,  -1, 1, 1'b0};
    vecs[1] = '{32'h0000_0000, 16'd40, -1, 3, 1'b0};
    vecs[2] = '{32'h0000_0FF0, 16'd8,  -1, 2, 1'b0};
    vecs[3] = '{32'h0000_2000, 16'd8,   2, 1, 1'b1};
    vecs[4] = '{32'h0000_3000, 16'd0,  -1, 0, 1'b0};
    vecs[5] = '{32'h0000_0F80, 16'd20, -1, 2, 1'b0};
    vecs[6] = '{32'h0000_1003, 16'd2,  -1, 1, 1'b0};
    vecs[7] = '{32'h0000_4008, 16'd33, -1, 3, 1'b0};

    #1 rst_n = 1'b0;
    #3 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_cmd(vecs[i], 0);

    // Backpressure with rvalid held high: rready must follow dout_ready 1-0-0-1.
    rv_pct = 100;
    v = '{32'h0000_5000, 16'd8, -1, 1, 1'b0};
    run_cmd(v, 1);
    rv_pct = 70;

    // Asynchronous reset in the middle of DATA.
    @(negedge clk); #2;
    err_target = -1;
    model_push(32'h0000_6000, 16'd32);
    b0 = beats_seen;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h0000_6000; cmd_beats = 16'd32; dout_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while ((beats_seen - b0) < 5 && n < 500) begin
      @(negedge clk); #2; n++;
    end
    chk("midreset_progress", 64'((beats_seen - b0) >= 5), 64'd1);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    exp_ar.delete();
    exp_dout.delete();
    repeat (2) @(negedge clk);
    #2 chk_reset_outputs("held_reset");
    @(negedge clk);
    rst_n = 1'b1;

    v = '{32'h0000_1000, 16'd3, -1, 1, 1'b0};
    run_cmd(v, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
